alu_operand_collector: RTL and testbench

ALU_OPERAND_COLLECTOR -- requirements
Module: alu_operand_collector

---
 rtl/alu_collector_pkg.sv | 37 +++
 rtl/alu_operand_collector_if.sv | 34 +++
 rtl/alu_opnd_slot.sv | 44 ++++
 rtl/define.sv | 6 +
 rtl/alu_operand_collector.sv | 169 ++++++++++++++++
 tb/tb_alu_operand_collector.sv | 242 ++++++++++++++++++++++++
 6 files changed

// File: rtl/alu_collector_pkg.sv
// Shared state type, timing constants and per-command operand-need decode.
`include "define.sv"
package alu_collector_pkg;
  localparam int W               = `WIDTH;
  localparam int CMD_W           = `CMD_WIDTH;
  localparam int TIMEOUT_CYCLES  = 16;
  localparam int MUL_HOLD_CYCLES = 2;

  typedef enum logic [1:0] {IDLE, COLLECT, ISSUE, HOLD} state_e;

  function automatic logic cmd_invalid(input logic mode, input logic [CMD_W-1:0] cmd);
    return mode ? (cmd > CMD_W'(10)) : (cmd > CMD_W'(13));
  endfunction

  function automatic logic only_a(input logic mode, input logic [CMD_W-1:0] cmd);
    return mode ? (cmd == CMD_W'(4) || cmd == CMD_W'(5))
                : (cmd == CMD_W'(6) || cmd == CMD_W'(8) || cmd == CMD_W'(9));
  endfunction

  function automatic logic only_b(input logic mode, input logic [CMD_W-1:0] cmd);
    return mode ? (cmd == CMD_W'(6) || cmd == CMD_W'(7))
                : (cmd == CMD_W'(7) || cmd == CMD_W'(10) || cmd == CMD_W'(11));
  endfunction

  function automatic logic need_a(input logic mode, input logic [CMD_W-1:0] cmd);
    return !cmd_invalid(mode, cmd) && !only_b(mode, cmd);
  endfunction

  function automatic logic need_b(input logic mode, input logic [CMD_W-1:0] cmd);
    return !cmd_invalid(mode, cmd) && !only_a(mode, cmd);
  endfunction

  // Multiplies keep the ALU busy, so the collector stalls new commands after them.
  function automatic logic is_mul(input logic mode, input logic [CMD_W-1:0] cmd);
    return mode && (cmd == CMD_W'(9) || cmd == CMD_W'(10));
  endfunction
endpackage

// File: rtl/alu_operand_collector_if.sv
// Command/operand handshakes and ALU-facing issue bus of the operand collector.
interface alu_operand_collector_if;
  import alu_collector_pkg::*;

  logic [CMD_W-1:0] CMD_IN;
  logic             MODE_IN;
  logic             CIN_IN;
  logic             CMD_VALID;
  logic             CMD_READY;
  logic [W-1:0]     A_DATA;
  logic             A_VALID;
  logic             A_READY;
  logic [W-1:0]     B_DATA;
  logic             B_VALID;
  logic             B_READY;
  logic [W-1:0]     OPA;
  logic [W-1:0]     OPB;
  logic [CMD_W-1:0] CMD;
  logic             MODE;
  logic             CIN;
  logic             CE;
  logic [1:0]       INP_VALID;
  logic             TIMEOUT_ERR;

  modport master (
    output CMD_IN, MODE_IN, CIN_IN, CMD_VALID, A_DATA, A_VALID, B_DATA, B_VALID,
    input  CMD_READY, A_READY, B_READY, OPA, OPB, CMD, MODE, CIN, CE, INP_VALID, TIMEOUT_ERR
  );

  modport slave (
    input  CMD_IN, MODE_IN, CIN_IN, CMD_VALID, A_DATA, A_VALID, B_DATA, B_VALID,
    output CMD_READY, A_READY, B_READY, OPA, OPB, CMD, MODE, CIN, CE, INP_VALID, TIMEOUT_ERR
  );
endinterface

// File: rtl/alu_opnd_slot.sv
// One operand holding register with a held flag; ready while enabled and empty.
module alu_opnd_slot
  import alu_collector_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic         rdy_en,
  input  logic [W-1:0] data_in,
  output logic         ready,
  output logic         held,
  output logic [W-1:0] data
);
  logic         held_q, held_d;
  logic [W-1:0] data_q, data_d;

  // Clear wins over load so a timed-out set never leaves a stale operand behind.
  always_comb begin
    held_d = held_q;
    data_d = data_q;
    if (clear) begin
      held_d = 1'b0;
      data_d = '0;
    end else if (load) begin
      held_d = 1'b1;
      data_d = data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held_q <= 1'b0;
      data_q <= '0;
    end else begin
      held_q <= held_d;
      data_q <= data_d;
    end
  end

  assign ready = rdy_en & ~held_q;
  assign held  = held_q;
  assign data  = data_q;
endmodule

// File: rtl/define.sv
// Global datapath widths for the ALU operand collector.
`ifndef ALU_COLLECTOR_DEFINE_SV
`define ALU_COLLECTOR_DEFINE_SV
`define WIDTH     8
`define CMD_WIDTH 4
`endif

// File: rtl/alu_operand_collector.sv
// Latches a command, gathers only the operands it needs, then pulses CE for one cycle (cmd->CE 2 cycles).
// COLLECT_TIMEOUT_EN adds a 16-cycle operand timeout with a TIMEOUT_ERR pulse; otherwise COLLECT waits forever.
module alu_operand_collector
  import alu_collector_pkg::*;
(
  input logic                   CLK,
  input logic                   RESET,
  alu_operand_collector_if.slave bus
);
  state_e           state_q, state_d;
  logic [CMD_W-1:0] cmd_q, cmd_d, cmd_o_q, cmd_o_d;
  logic             mode_q, mode_d, cin_q, cin_d;
  logic             mode_o_q, mode_o_d, cin_o_q, cin_o_d;
  logic [W-1:0]     opa_q, opa_d, opb_q, opb_d;
  logic [1:0]       inp_valid_q, inp_valid_d;
  logic [1:0]       hold_cnt_q, hold_cnt_d;
  logic             need_a_w, need_b_w, in_collect;
  logic             a_ready, b_ready, a_load, b_load, a_held, b_held;
  logic [W-1:0]     a_dat, b_dat;
  logic             slot_clear, all_done, timeout_hit;

  assign need_a_w   = need_a(mode_q, cmd_q);
  assign need_b_w   = need_b(mode_q, cmd_q);
  assign in_collect = (state_q == COLLECT) && !RESET;
  assign a_load     = bus.A_VALID & a_ready;
  assign b_load     = bus.B_VALID & b_ready;
  // An operand arriving this cycle counts, so ISSUE follows the last acceptance directly.
  assign all_done   = (!need_a_w || a_held || a_load) && (!need_b_w || b_held || b_load);

  alu_opnd_slot u_slot_a (
    .clk(CLK), .rst(RESET), .load(a_load), .clear(slot_clear),
    .rdy_en(in_collect && need_a_w), .data_in(bus.A_DATA),
    .ready(a_ready), .held(a_held), .data(a_dat)
  );

  alu_opnd_slot u_slot_b (
    .clk(CLK), .rst(RESET), .load(b_load), .clear(slot_clear),
    .rdy_en(in_collect && need_b_w), .data_in(bus.B_DATA),
    .ready(b_ready), .held(b_held), .data(b_dat)
  );

`ifdef COLLECT_TIMEOUT_EN
  logic [4:0] tmo_cnt_q, tmo_cnt_d;
  logic       tmo_err_q, tmo_err_d;

  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == COLLECT) tmo_cnt_d = tmo_cnt_q + 5'd1;
  end

  assign timeout_hit = (state_q == COLLECT) && (tmo_cnt_q == 5'(TIMEOUT_CYCLES - 1)) && !all_done;
  assign tmo_err_d   = timeout_hit;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign bus.TIMEOUT_ERR = tmo_err_q & ~RESET;
`else
  assign timeout_hit     = 1'b0;
  assign bus.TIMEOUT_ERR = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    mode_d      = mode_q;
    cin_d       = cin_q;
    cmd_o_d     = cmd_o_q;
    mode_o_d    = mode_o_q;
    cin_o_d     = cin_o_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    inp_valid_d = inp_valid_q;
    hold_cnt_d  = hold_cnt_q;
    slot_clear  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.CMD_VALID) begin
          cmd_d      = bus.CMD_IN;
          mode_d     = bus.MODE_IN;
          cin_d      = bus.CIN_IN;
          slot_clear = 1'b1;
          if (cmd_invalid(bus.MODE_IN, bus.CMD_IN)) begin
            state_d     = ISSUE;
            cmd_o_d     = bus.CMD_IN;
            mode_o_d    = bus.MODE_IN;
            cin_o_d     = bus.CIN_IN;
            opa_d       = '0;
            opb_d       = '0;
            inp_valid_d = 2'b00;
          end else begin
            state_d = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (all_done) begin
          state_d     = ISSUE;
          cmd_o_d     = cmd_q;
          mode_o_d    = mode_q;
          cin_o_d     = cin_q;
          opa_d       = a_load ? bus.A_DATA : a_dat;
          opb_d       = b_load ? bus.B_DATA : b_dat;
          inp_valid_d = {b_held | b_load, a_held | a_load};
        end else if (timeout_hit) begin
          state_d    = IDLE;
          slot_clear = 1'b1;
        end
      end
      ISSUE: begin
        slot_clear = 1'b1;
        hold_cnt_d = '0;
        state_d    = is_mul(mode_q, cmd_q) ? HOLD : IDLE;
      end
      HOLD: begin
        hold_cnt_d = hold_cnt_q + 2'd1;
        if (hold_cnt_q == 2'(MUL_HOLD_CYCLES - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      mode_q      <= 1'b0;
      cin_q       <= 1'b0;
      cmd_o_q     <= '0;
      mode_o_q    <= 1'b0;
      cin_o_q     <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      inp_valid_q <= 2'b00;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      mode_q      <= mode_d;
      cin_q       <= cin_d;
      cmd_o_q     <= cmd_o_d;
      mode_o_q    <= mode_o_d;
      cin_o_q     <= cin_o_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      inp_valid_q <= inp_valid_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  // Outputs are forced low for the whole reset assertion, not just after the first edge.
  assign bus.CMD_READY = (state_q == IDLE) && !RESET;
  assign bus.CE        = (state_q == ISSUE) && !RESET;
  assign bus.A_READY   = a_ready;
  assign bus.B_READY   = b_ready;
  assign bus.OPA       = RESET ? '0 : opa_q;
  assign bus.OPB       = RESET ? '0 : opb_q;
  assign bus.CMD       = RESET ? '0 : cmd_o_q;
  assign bus.MODE      = mode_o_q & ~RESET;
  assign bus.CIN       = cin_o_q & ~RESET;
  assign bus.INP_VALID = RESET ? 2'b00 : inp_valid_q;
endmodule

// File: tb/tb_alu_operand_collector.sv
// Scoreboard bench for alu_operand_collector: table-driven reference model, randomized and directed commands.
module tb_alu_operand_collector;
  import alu_collector_pkg::*;

  logic CLK;
  logic RESET;
  alu_operand_collector_if bus();

  alu_operand_collector dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Operand needs per command, bit0 = A, bit1 = B, 0 = invalid command.
  localparam logic [1:0] NEED_M1 [16] = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd1, 2'd1, 2'd2, 2'd2,
                                          2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
  localparam logic [1:0] NEED_M0 [16] = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd1, 2'd2,
                                          2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};

  typedef struct {
    logic             mode;
    logic [CMD_W-1:0] cmd;
    logic             cin;
    logic [1:0]       iv;
    logic [W-1:0]     opa;
    logic [W-1:0]     opb;
    int               ce_cyc;
    bit               mul;
  } exp_t;

  exp_t sbq[$];
  exp_t last;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   issued = 0;
  int   pushed = 0;
  int   tmo_seen = 0;
  int   tmo_exp_cnt = 0;
  int   tmo_cyc = 0;
  bit   tmo_expect = 0;
  bit   hold_chk = 0;
  bit   ready_chk_pending = 0;
  int   last_ce_cyc = 0;
  bit   last_mul = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    else pass_cnt++;
  endtask

  // Monitor: samples 1 time unit after each rising edge and retires scoreboard entries on CE.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (hold_chk) begin
        hold_chk = 0;
        chk("ce_one_cycle", bus.CE, 1'b0);
        chk("hold_opa", bus.OPA, last.opa);
        chk("hold_opb", bus.OPB, last.opb);
        chk("hold_iv", bus.INP_VALID, last.iv);
        chk("hold_cmd", bus.CMD, last.cmd);
      end
      if (bus.TIMEOUT_ERR) begin
        chk("tmo_expected", tmo_expect, 1'b1);
        tmo_seen++;
        tmo_cyc = cyc;
      end
      if (bus.CE) begin
        chk("ce_has_entry", sbq.size() != 0, 1'b1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("ce_cycle", cyc, e.ce_cyc);
          chk("cmd", bus.CMD, e.cmd);
          chk("mode", bus.MODE, e.mode);
          chk("cin", bus.CIN, e.cin);
          chk("inp_valid", bus.INP_VALID, e.iv);
          chk("opa", bus.OPA, e.opa);
          chk("opb", bus.OPB, e.opb);
          last = e;
          last_mul = e.mul;
          hold_chk = 1;
        end
        issued++;
        last_ce_cyc = cyc;
        ready_chk_pending = 1;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Called at a falling edge; waits for CMD_READY and checks post-issue stall length.
  task automatic wait_cmd_ready();
    int k;
    k = 0;
    while (!bus.CMD_READY && k < 20) begin
      @(negedge CLK);
      k++;
    end
    chk("cmd_ready_seen", bus.CMD_READY, 1'b1);
    if (ready_chk_pending) begin
      chk("cmd_ready_cycle", cyc, last_ce_cyc + (last_mul ? 3 : 1));
      ready_chk_pending = 0;
    end
  endtask

  task automatic do_cmd(input logic mode, input logic [CMD_W-1:0] cmd, input logic cin,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input int da, input int db, input bit give_b);
    exp_t       e;
    logic [1:0] nd;
    int         c, lat, start_issued, start_tmo;
    bit         a_done, b_done, a_bad, b_bad, done, tmo_case;
    nd = mode ? NEED_M1[cmd] : NEED_M0[cmd];
    tmo_case = nd[1] && !give_b;
    wait_cmd_ready();
    c = cyc;
    bus.CMD_IN = cmd; bus.MODE_IN = mode; bus.CIN_IN = cin; bus.CMD_VALID = 1'b1;
    lat = 0;
    if (nd[0] && da > lat) lat = da;
    if (nd[1] && db > lat) lat = db;
    e.mode = mode; e.cmd = cmd; e.cin = cin; e.iv = nd;
    e.opa = nd[0] ? a : '0;
    e.opb = nd[1] ? b : '0;
    e.ce_cyc = (nd == 2'b00) ? c + 1 : c + 2 + lat;
    e.mul = mode && (cmd == 9 || cmd == 10);
    if (tmo_case) begin
      tmo_expect = 1;
      tmo_exp_cnt++;
    end else begin
      sbq.push_back(e);
      pushed++;
    end
    start_issued = issued;
    start_tmo = tmo_seen;
    a_done = 0; b_done = 0; a_bad = 0; b_bad = 0; done = 0;
    @(negedge CLK);
    bus.CMD_VALID = 1'b0;
    for (int i = 0; i < 64; i++) begin
      bus.A_VALID = !a_done && (i >= da);
      bus.A_DATA  = a;
      bus.B_VALID = give_b && !b_done && (i >= db);
      bus.B_DATA  = b;
      if (bus.A_READY && !nd[0]) a_bad = 1;
      if (bus.B_READY && !nd[1]) b_bad = 1;
      if (bus.A_VALID && bus.A_READY) a_done = 1;
      if (bus.B_VALID && bus.B_READY) b_done = 1;
      if (issued != start_issued || tmo_seen != start_tmo) begin
        done = 1;
        break;
      end
      @(negedge CLK);
    end
    bus.A_VALID = 1'b0;
    bus.B_VALID = 1'b0;
    chk("txn_completed", done, 1'b1);
    chk("a_ready_unneeded", a_bad, 1'b0);
    chk("b_ready_unneeded", b_bad, 1'b0);
    if (tmo_case) begin
      chk("tmo_cycle", tmo_cyc, c + 17);
      tmo_expect = 0;
      ready_chk_pending = 0;
    end
  endtask

  initial begin
    RESET = 1'b1;
    bus.CMD_VALID = 1'b0; bus.CMD_IN = '0; bus.MODE_IN = 1'b0; bus.CIN_IN = 1'b0;
    bus.A_VALID = 1'b0; bus.A_DATA = '0; bus.B_VALID = 1'b0; bus.B_DATA = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_cmd_ready", bus.CMD_READY, 1'b0);
    chk("rst_ce", bus.CE, 1'b0);
    chk("rst_inp_valid", bus.INP_VALID, 2'b00);
    chk("rst_tmo", bus.TIMEOUT_ERR, 1'b0);
    chk("rst_opa", bus.OPA, 0);
    chk("rst_a_ready", bus.A_READY, 1'b0);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    chk("cmd_ready_after_rst", bus.CMD_READY, 1'b1);

    do_cmd(1'b1, 4'd0, 1'b0, 8'h05, 8'h03, 0, 0, 1);
    do_cmd(1'b0, 4'd6, 1'b1, 8'hF0, 8'hAA, 0, 0, 1);
    do_cmd(1'b1, 4'd9, 1'b0, 8'h12, 8'h34, 0, 1, 1);
    do_cmd(1'b1, 4'd10, 1'b1, 8'h56, 8'h78, 2, 0, 1);
    do_cmd(1'b0, 4'd14, 1'b0, 8'h11, 8'h22, 0, 0, 1);
    do_cmd(1'b1, 4'd11, 1'b1, 8'h33, 8'h44, 0, 0, 1);
    do_cmd(1'b0, 4'd13, 1'b0, 8'h9C, 8'hC9, 1, 3, 1);
    do_cmd(1'b1, 4'd6, 1'b0, 8'h01, 8'h02, 0, 2, 1);
`ifdef COLLECT_TIMEOUT_EN
    do_cmd(1'b1, 4'd0, 1'b0, 8'hA5, 8'h5A, 0, 0, 0);
    do_cmd(1'b1, 4'd0, 1'b1, 8'hC3, 8'h3C, 0, 15, 1);
`endif

    // Reset while A is held and B is still outstanding.
    wait_cmd_ready();
    bus.MODE_IN = 1'b1; bus.CMD_IN = 4'd0; bus.CIN_IN = 1'b0; bus.CMD_VALID = 1'b1;
    @(negedge CLK);
    bus.CMD_VALID = 1'b0; bus.A_VALID = 1'b1; bus.A_DATA = 8'h77;
    @(negedge CLK);
    bus.A_VALID = 1'b0;
    chk("collect_waiting_b", bus.B_READY, 1'b1);
    chk("collect_a_held", bus.A_READY, 1'b0);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    chk("rst_mid_cmd_ready", bus.CMD_READY, 1'b0);
    chk("rst_mid_b_ready", bus.B_READY, 1'b0);
    chk("rst_mid_iv", bus.INP_VALID, 2'b00);
    chk("rst_mid_opa", bus.OPA, 0);
    @(negedge CLK);
    RESET = 1'b0;
    ready_chk_pending = 0;
    @(negedge CLK);
    chk("rst_release_cmd_ready", bus.CMD_READY, 1'b1);
    chk("rst_release_iv", bus.INP_VALID, 2'b00);
    do_cmd(1'b1, 4'd0, 1'b1, 8'hDE, 8'hAD, 0, 0, 1);

    for (int n = 0; n < 40; n++) begin
      do_cmd(1'($urandom_range(0, 1)), CMD_W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             W'($urandom), W'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1);
    end

    repeat (4) @(negedge CLK);
    chk("issued_count", issued, pushed);
    chk("scoreboard_empty", sbq.size(), 0);
    chk("timeout_count", tmo_seen, tmo_exp_cnt);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
